// File: rtl/pm_fault_sequencer_if.sv
// pm_fault_sequencer_if: power-monitor inputs and sequencer status outputs.
// The master drives the monitor inputs; the slave (the sequencer) drives status.
interface pm_fault_sequencer_if;
    logic        fault;
    logic        warn;
    logic        eoc;
    logic [31:0] pgood_bus;
    logic        clr_status;
    logic [31:0] pg_stable;
    logic [31:0] pg_lost;
    logic [1:0]  state;
    logic        shutdown;
    logic        irq;
    logic [7:0]  eoc_count;

    modport master (
        output fault, warn, eoc, pgood_bus, clr_status,
        input  pg_stable, pg_lost, state, shutdown, irq, eoc_count
    );

    modport slave (
        input  fault, warn, eoc, pgood_bus, clr_status,
        output pg_stable, pg_lost, state, shutdown, irq, eoc_count
    );
endinterface

// File: rtl/pm_fault_sequencer.sv
// pm_fault_sequencer: debounced power-good monitor driving an INIT/RUN/WARN/SHUTDOWN sequencer.
// Define PM_FAULT_SEQUENCER_EOC_CNT_EN to enable the EOC event counter and its interrupt source.
module pm_fault_sequencer #(
    parameter int NumConverters  = 1,
    parameter int DebounceCycles = 4
) (
    input logic                 clock,
    input logic                 reset_n,
    pm_fault_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        INIT     = 2'b00,
        RUN      = 2'b01,
        WARN     = 2'b10,
        SHUTDOWN = 2'b11
    } state_e;

    localparam logic [31:0] Mask = 32'hFFFF_FFFF >> (32 - NumConverters);

    state_e      state_q, state_d;
    logic [31:0] stable_q, stable_prev_q, lost_q;
    logic [7:0]  cnt_q [NumConverters];
    logic [7:0]  eoc_q;
    logic        shutdown_q, irq_q, irq_set, eoc_set;
    logic        any_lost, all_good, active;

    assign any_lost = |lost_q;
    assign all_good = &(stable_q | ~Mask);
    assign active   = (state_q == RUN) || (state_q == WARN);

    // Bits at or above NumConverters are never written and stay at their reset value of 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= '0;
            for (int i = 0; i < NumConverters; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NumConverters; i++) begin
                if (bus.pgood_bus[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == 8'(DebounceCycles - 1)) begin
                    stable_q[i] <= bus.pgood_bus[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // A fall is seen one cycle after pg_stable drops, so losses land the cycle after the drop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable_prev_q <= '0;
            lost_q        <= '0;
        end else begin
            stable_prev_q <= stable_q;
            lost_q        <= (bus.clr_status ? '0 : lost_q) | (active ? (stable_prev_q & ~stable_q) : '0);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:     state_d = bus.fault ? SHUTDOWN : all_good ? RUN : INIT;
            RUN:      state_d = (bus.fault || any_lost) ? SHUTDOWN : bus.warn ? WARN : RUN;
            WARN:     state_d = (bus.fault || any_lost) ? SHUTDOWN : !bus.warn ? RUN : WARN;
            SHUTDOWN: state_d = (bus.clr_status && !bus.fault) ? INIT : SHUTDOWN;
            default:  state_d = INIT;
        endcase
        irq_set = (state_d != state_q) && ((state_d == WARN) || (state_d == SHUTDOWN));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            shutdown_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shutdown_q <= state_d == SHUTDOWN;
            irq_q      <= irq_set | eoc_set | (irq_q & ~bus.clr_status);
        end
    end

`ifdef PM_FAULT_SEQUENCER_EOC_CNT_EN
    assign eoc_set = bus.eoc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) eoc_q <= '0;
        else eoc_q <= bus.clr_status ? {7'd0, bus.eoc} : eoc_q + {7'd0, bus.eoc};
    end
`else
    logic eoc_unused;
    assign eoc_unused = bus.eoc;
    assign eoc_set    = 1'b0;
    assign eoc_q      = '0;
`endif

    assign bus.pg_stable = stable_q;
    assign bus.pg_lost   = lost_q;
    assign bus.state     = state_q;
    assign bus.shutdown  = shutdown_q;
    assign bus.irq       = irq_q;
    assign bus.eoc_count = eoc_q;
endmodule

// File: tb/tb_pm_fault_sequencer.sv
// tb_pm_fault_sequencer: randomized stimulus checked against a sample-history reference model.
// Runs with NumConverters=4, DebounceCycles=4; honours PM_FAULT_SEQUENCER_EOC_CNT_EN.
module tb_pm_fault_sequencer;
    localparam int N = 4;
    localparam int D = 4;
`ifdef PM_FAULT_SEQUENCER_EOC_CNT_EN
    localparam bit EocEn = 1'b1;
`else
    localparam bit EocEn = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n;
    int   n_total = 0;
    int   n_pass  = 0;

    pm_fault_sequencer_if bif ();

    pm_fault_sequencer #(.NumConverters(N), .DebounceCycles(D)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bif.slave)
    );

    always #5 clock = ~clock;

    // Reference model: stable value flips once the last D samples all disagree with it.
    int         m_state;
    logic [3:0] m_stable, m_lost, m_fell;
    logic [3:0] hist [N];
    logic       m_irq;
    logic [7:0] m_eoc;
    int         drop_left [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_stable = '0;
        m_lost   = '0;
        m_fell   = '0;
        m_irq    = 1'b0;
        m_eoc    = '0;
        for (int b = 0; b < N; b++) hist[b] = '0;
    endtask

    task automatic model_step();
        int         ns;
        logic [3:0] nl, nst;
        ns = m_state;
        if (m_state == 0) ns = bif.fault ? 3 : (m_stable == 4'hF ? 1 : 0);
        else if (m_state == 3) ns = (bif.clr_status && !bif.fault) ? 0 : 3;
        else if (bif.fault || m_lost != 0) ns = 3;
        else if (m_state == 1 && bif.warn) ns = 2;
        else if (m_state == 2 && !bif.warn) ns = 1;
        nl = (bif.clr_status ? 4'h0 : m_lost) | ((m_state == 1 || m_state == 2) ? m_fell : 4'h0);
        nst = m_stable;
        for (int b = 0; b < N; b++) begin
            hist[b] = {hist[b][2:0], bif.pgood_bus[b]};
            if (hist[b] == {4{~m_stable[b]}}) nst[b] = bif.pgood_bus[b];
        end
        m_fell = m_stable & ~nst;
        m_irq  = (ns != m_state && ns >= 2) || (EocEn && bif.eoc) || (m_irq && !bif.clr_status);
        if (EocEn) m_eoc = bif.clr_status ? {7'd0, bif.eoc} : m_eoc + {7'd0, bif.eoc};
        m_state  = ns;
        m_lost   = nl;
        m_stable = nst;
    endtask

    task automatic compare_all(input string pfx);
        check({pfx, "pg_stable"}, bif.pg_stable, {28'd0, m_stable});
        check({pfx, "pg_lost"}, bif.pg_lost, {28'd0, m_lost});
        check({pfx, "state"}, {30'd0, bif.state}, 32'(m_state));
        check({pfx, "shutdown"}, {31'd0, bif.shutdown}, {31'd0, m_state == 3});
        check({pfx, "irq"}, {31'd0, bif.irq}, {31'd0, m_irq});
        check({pfx, "eoc_count"}, {24'd0, bif.eoc_count}, {24'd0, m_eoc});
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        compare_all("");
    endtask

    // Asserts reset between edges and checks outputs before any clock edge arrives.
    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("rst_");
        @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic drive_random();
        logic [31:0] r;
        logic [3:0]  pg;
        r = $urandom();
        for (int b = 0; b < N; b++) begin
            if (drop_left[b] > 0) begin
                pg[b] = 1'b0;
                drop_left[b]--;
            end else begin
                pg[b] = 1'b1;
                if ($urandom_range(0, 99) < 3) drop_left[b] = $urandom_range(1, 7);
            end
        end
        bif.pgood_bus  = {r[31:4], pg};
        bif.fault      = $urandom_range(0, 99) < 2;
        bif.clr_status = $urandom_range(0, 99) < 6;
        bif.eoc        = $urandom_range(0, 99) < 20;
        if ($urandom_range(0, 99) < 10) bif.warn = ~bif.warn;
    endtask

    initial begin
        reset_n        = 1'b1;
        bif.fault      = 1'b0;
        bif.warn       = 1'b0;
        bif.eoc        = 1'b0;
        bif.clr_status = 1'b0;
        bif.pgood_bus  = 32'hA5A5_A5AF;
        for (int b = 0; b < N; b++) drop_left[b] = 0;
        #1;
        async_reset();
        for (int k = 0; k < 8; k++) cycle();
        for (int k = 0; k < 3000; k++) begin
            drive_random();
            cycle();
            if ($urandom_range(0, 999) < 3) async_reset();
        end
        bif.pgood_bus  = 32'h0000_000F;
        bif.fault      = 1'b0;
        bif.warn       = 1'b0;
        bif.eoc        = 1'b0;
        bif.clr_status = 1'b1;
        cycle();
        bif.clr_status = 1'b0;
        bif.eoc        = 1'b1;
        for (int k = 0; k < 257; k++) cycle();
        bif.eoc = 1'b0;
        cycle();
        bif.fault = 1'b1;
        cycle();
        cycle();
        async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pm_fault_sequencer.md
PM_FAULT_SEQUENCER -- requirements
Module: pm_fault_sequencer

Interface
REQ-001 The block SHALL have parameter NumConverters, default 1, meaning the number of active pgood_bus bits (1..32).
REQ-002 The block SHALL have parameter DebounceCycles, default 4, meaning the consecutive-cycle filter length (1..255).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clock  input  1  sole clock, all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 fault  input  1  power-monitor fault level.
REQ-006 warn  input  1  power-monitor warn level.
REQ-007 eoc  input  1  end-of-conversion pulse.
REQ-008 pgood_bus  input  32  per-converter power-good, bus mode.
REQ-009 clr_status  input  1  single-cycle firmware clear/acknowledge.
REQ-010 pg_stable  output  32  debounced pgood.
REQ-011 pg_lost  output  32  sticky per-converter pgood-loss flags.
REQ-012 state  output  2  FSM state code.
REQ-013 shutdown  output  1  converter shutdown request.
REQ-014 irq  output  1  level interrupt.
REQ-015 eoc_count  output  8  EOC event counter.

Function
REQ-016 Per bit i < NumConverters, pg_stable[i] SHALL take the value of pgood_bus[i] once that value has differed from pg_stable[i] for DebounceCycles consecutive clocks; any return to agreement SHALL zero that bit's counter.
REQ-017 pg_stable and pg_lost bits at index >= NumConverters SHALL be constant 0; their pgood_bus bits SHALL be ignored.
REQ-018 pg_lost[i] SHALL set on the cycle after pg_stable[i] goes 1->0 while state is RUN or WARN, and SHALL hold until clr_status.
REQ-019 FSM states: INIT=2'b00, RUN=2'b01, WARN=2'b10, SHUTDOWN=2'b11.
REQ-020 INIT -> RUN when all pg_stable[NumConverters-1:0] are 1 and fault=0; INIT -> SHUTDOWN when fault=1.
REQ-021 RUN -> SHUTDOWN on fault=1 or any pg_lost bit set; otherwise RUN -> WARN on warn=1.
REQ-022 WARN -> SHUTDOWN on fault=1 or any pg_lost bit set; otherwise WARN -> RUN on warn=0.
REQ-023 SHUTDOWN -> INIT on clr_status=1 with fault=0; otherwise it SHALL hold, with fault taking priority over clr_status.
REQ-024 shutdown SHALL be 1 exactly while state is SHUTDOWN, as a registered output with no extra delay.
REQ-025 irq SHALL set on any transition into WARN or SHUTDOWN and SHALL clear on clr_status.
REQ-026 When an irq set and clr_status occur in the same cycle, the set SHALL win.
REQ-027 clr_status SHALL clear all pg_lost bits in the cycle it is sampled; a new loss in that same cycle SHALL remain set.

Reset
REQ-028 On reset_n=0, state SHALL be INIT and pg_stable, pg_lost, debounce counters, shutdown, irq and eoc_count SHALL be 0, without waiting for a clock edge.
REQ-029 Reset asserted mid-debounce or in SHUTDOWN SHALL abandon all progress; after release the block SHALL restart from INIT.

Configuration
REQ-030 With macro PM_FAULT_SEQUENCER_EOC_CNT_EN defined, eoc_count SHALL increment by 1 on each clock with eoc=1 and SHALL wrap 255->0.
REQ-031 With that macro defined, clr_status SHALL zero eoc_count; when clr_status and eoc coincide, eoc_count SHALL become 1.
REQ-032 With that macro defined, eoc=1 SHALL also set irq.
REQ-033 Without that macro, eoc SHALL be ignored and eoc_count SHALL be constant 0.

Verification (NumConverters=4, DebounceCycles=4)
REQ-034 pgood_bus=0x0000000F from reset -> pg_stable=0x0F after 4 clocks; state INIT->RUN the next clock; irq=0.
REQ-035 In RUN, a 3-cycle glitch of bit 2 to 0 -> pg_stable stays 0x0F and pg_lost stays 0; a 4-cycle drop -> pg_lost=0x04, state=SHUTDOWN, shutdown=1, irq=1.
REQ-036 In RUN, warn=1 for 10 cycles then 0 -> state=WARN then RUN; irq=1 until clr_status pulse, then 0.
REQ-037 In SHUTDOWN, clr_status with fault=1 -> state stays SHUTDOWN; clr_status with fault=0 -> INIT, pg_lost=0, irq=0.
REQ-038 With the macro defined, 257 eoc pulses -> eoc_count=1 and irq=1; with the macro undefined, eoc_count=0 and irq=0.
REQ-039 reset_n=0 asserted in SHUTDOWN between clock edges -> shutdown=0 and state=INIT immediately.
